pixel_stream_proc: RTL

//  Streaming RGB point-operation engine; successor to the frame-memory image reader.

---
 rtl/pixel_stream_proc.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pixel_stream_proc.sv
// pixel_stream_proc: streaming RGB point-operation engine with line/frame sideband.
module pixel_stream_proc #(
  parameter int WIDTH = 768,
  parameter int HEIGHT = 512,
  parameter int DW = 8,
  parameter int LANES = 2,
  parameter logic [2:0] MODE_DEF = 3'd0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [2:0]              cfg_mode,
  input  logic [DW-1:0]           cfg_value,
  input  logic [DW-1:0]           cfg_thr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*3*DW-1:0]   in_data,
  input  logic                    in_sof,
  input  logic                    in_eol,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*3*DW-1:0]   out_data,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof,
  output logic                    err_len,
  output logic                    frame_done
);
  localparam int BPL = WIDTH / LANES;
  localparam int CW = BPL > 1 ? $clog2(BPL) : 1;
  localparam int RW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(BPL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [DW-1:0] MAX = '1;

  logic en, acc, col_end, len_bad, beat_eof, wrap;
  logic [CW-1:0] col, cur_col;
  logic [RW-1:0] row, cur_row;
  logic [2:0] mode_q, mode;
  logic [DW-1:0] value_q, thr_q, value, thr;
  logic [LANES*3*DW-1:0] res, s1_data;
  logic s1_valid, s1_sof, s1_eol, s1_eof;

  function automatic logic [3*DW-1:0] px_op(input logic [2:0] m, input logic [3*DW-1:0] p,
                                            input logic [DW-1:0] v, input logic [DW-1:0] t);
    logic [DW+1:0] sum, q;
    logic [DW-1:0] avg, y;
    logic [DW:0] add;
    sum = {2'b00, p[2*DW +: DW]} + {2'b00, p[DW +: DW]} + {2'b00, p[0 +: DW]};
    q = sum / (DW+2)'(3);
    avg = q[DW-1:0];
    px_op = p;
    for (int c = 0; c < 3; c++) begin
      y = p[c*DW +: DW];
      add = {1'b0, y} + {1'b0, v};
      px_op[c*DW +: DW] = m == 3'd1 ? (add[DW] ? MAX : add[DW-1:0]) :
                          m == 3'd2 ? (y > v ? y - v : '0) :
                          m == 3'd3 ? MAX - avg :
                          m == 3'd4 ? (avg > t ? MAX : '0) : y;
    end
  endfunction

  assign en = ~out_valid | out_ready;
  assign in_ready = en;
  assign acc = in_valid & en;

  // A start-of-frame beat is always col 0 / row 0 and uses the config presented with it.
  assign cur_col = in_sof ? '0 : col;
  assign cur_row = in_sof ? '0 : row;
  assign col_end = cur_col == COL_LAST;
  assign len_bad = in_eol != col_end;
  assign wrap = in_eol | col_end;
  assign beat_eof = col_end & (cur_row == ROW_LAST);
  assign mode = in_sof ? cfg_mode : mode_q;
  assign value = in_sof ? cfg_value : value_q;
  assign thr = in_sof ? cfg_thr : thr_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign res[k*3*DW +: 3*DW] = px_op(mode, in_data[k*3*DW +: 3*DW], value, thr);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_sof <= 1'b0;
      s1_eol <= 1'b0;
      s1_eof <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
      out_eof <= 1'b0;
      err_len <= 1'b0;
      frame_done <= 1'b0;
      col <= '0;
      row <= '0;
      mode_q <= MODE_DEF;
      value_q <= '0;
      thr_q <= '0;
    end else begin
      err_len <= acc & len_bad;
      frame_done <= out_valid & out_ready & out_eof;
      if (en) begin
        s1_valid <= in_valid;
        s1_data <= res;
        s1_sof <= in_valid & in_sof;
        s1_eol <= in_valid & in_eol;
        s1_eof <= in_valid & beat_eof;
        out_valid <= s1_valid;
        out_data <= s1_data;
        out_sof <= s1_sof;
        out_eol <= s1_eol;
        out_eof <= s1_eof;
      end
      if (acc) begin
        col <= wrap ? '0 : cur_col + CW'(1);
        row <= wrap ? (cur_row == ROW_LAST ? '0 : cur_row + RW'(1)) : cur_row;
        if (in_sof) begin
          mode_q <= cfg_mode;
          value_q <= cfg_value;
          thr_q <= cfg_thr;
        end
      end
    end
  end
endmodule
